mr_wb: RTL and testbench

MR_WB -- requirements
Module: mr_wb

---
 rtl/mr_wb_if.sv | 43 ++++
 rtl/mr_wb.sv | 144 ++++++++++++++
 tb/tb_mr_wb.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mr_wb_if.sv
// Writeback bundle: load/store and ALU result inputs, issue notification,
// register read ports and the retired-instruction counter.
interface mr_wb_if #(
  parameter int XLEN        = 32,
  parameter int REGSEL_BITS = 5
);
  logic                   ldst_write_i;
  logic [XLEN-1:0]        ldst_payload_i;
  logic [REGSEL_BITS-1:0] ldst_dst_reg_i;
  logic                   alu_valid_i;
  logic [XLEN-1:0]        alu_payload_i;
  logic [REGSEL_BITS-1:0] alu_dst_reg_i;
  logic                   alu_ready_o;
  logic                   iss_valid_i;
  logic [REGSEL_BITS-1:0] iss_dst_reg_i;
  logic [REGSEL_BITS-1:0] rs1_sel_i;
  logic [REGSEL_BITS-1:0] rs2_sel_i;
  logic [XLEN-1:0]        rs1_data_o;
  logic [XLEN-1:0]        rs2_data_o;
  logic                   rs1_busy_o;
  logic                   rs2_busy_o;
  logic [63:0]            instret_o;

  modport slave (
    input  ldst_write_i, ldst_payload_i, ldst_dst_reg_i,
    input  alu_valid_i, alu_payload_i, alu_dst_reg_i,
    output alu_ready_o,
    input  iss_valid_i, iss_dst_reg_i,
    input  rs1_sel_i, rs2_sel_i,
    output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o,
    output instret_o
  );

  modport master (
    output ldst_write_i, ldst_payload_i, ldst_dst_reg_i,
    output alu_valid_i, alu_payload_i, alu_dst_reg_i,
    input  alu_ready_o,
    output iss_valid_i, iss_dst_reg_i,
    output rs1_sel_i, rs2_sel_i,
    input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o,
    input  instret_o
  );
endinterface

// File: rtl/mr_wb.sv
// Writeback stage: arbitrates LDST and ALU results into a single commit per
// cycle, owns the register file, the busy scoreboard and the retire counter.
module mr_wb #(
  parameter int XLEN        = 32,
  parameter int REGSEL_BITS = 5
) (
  input  logic   clk,
  input  logic   reset,
  mr_wb_if.slave bus
);
  localparam int NREGS = 1 << REGSEL_BITS;

  typedef enum logic {S_EMPTY, S_FULL} hold_state_t;

  hold_state_t            r_state;
  hold_state_t            w_state_next;
  logic [XLEN-1:0]        r_hold_data;
  logic [REGSEL_BITS-1:0] r_hold_reg;
  logic [XLEN-1:0]        r_regs [NREGS];
  logic [NREGS-1:0]       r_busy;
  logic [NREGS-1:0]       w_busy_next;
  logic [63:0]            r_instret;

  logic                   w_alu_ready;
  logic                   w_hold_load;
  logic                   w_commit;
  logic [XLEN-1:0]        w_commit_data;
  logic [REGSEL_BITS-1:0] w_commit_reg;

  logic [REGSEL_BITS-1:0] w_sel   [2];
  logic [XLEN-1:0]        w_rdata [2];
  logic                   w_rbusy [2];

  // LDST is never stalled, so a displaced ALU result waits in the holding
  // buffer and drains on the first LDST-free cycle, keeping ALU order.
  always_comb begin
    w_state_next  = r_state;
    w_alu_ready   = 1'b0;
    w_hold_load   = 1'b0;
    w_commit      = 1'b0;
    w_commit_data = '0;
    w_commit_reg  = '0;
    if (!reset) begin
      w_alu_ready = (r_state == S_EMPTY);
      unique case (r_state)
        S_EMPTY: begin
          if (bus.ldst_write_i) begin
            w_commit      = 1'b1;
            w_commit_data = bus.ldst_payload_i;
            w_commit_reg  = bus.ldst_dst_reg_i;
            if (bus.alu_valid_i) begin
              w_hold_load  = 1'b1;
              w_state_next = S_FULL;
            end
          end else if (bus.alu_valid_i) begin
            w_commit      = 1'b1;
            w_commit_data = bus.alu_payload_i;
            w_commit_reg  = bus.alu_dst_reg_i;
          end
        end
        S_FULL: begin
          w_commit = 1'b1;
          if (bus.ldst_write_i) begin
            w_commit_data = bus.ldst_payload_i;
            w_commit_reg  = bus.ldst_dst_reg_i;
          end else begin
            w_commit_data = r_hold_data;
            w_commit_reg  = r_hold_reg;
            w_state_next  = S_EMPTY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hold_load) begin
      r_hold_data <= bus.alu_payload_i;
      r_hold_reg  <= bus.alu_dst_reg_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && (w_commit_reg != '0)) begin
      r_regs[w_commit_reg] <= w_commit_data;
    end
  end

  // Issue is applied after the commit clear so a same-edge re-issue wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_commit) begin
      w_busy_next[w_commit_reg] = 1'b0;
    end
    if (!reset && bus.iss_valid_i) begin
      w_busy_next[bus.iss_dst_reg_i] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= '0;
      r_instret <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_commit) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  assign w_sel[0] = bus.rs1_sel_i;
  assign w_sel[1] = bus.rs2_sel_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rport
    logic w_bypass;
    logic w_iss_hit;
    assign w_bypass   = w_commit && (w_sel[gi] == w_commit_reg) && (w_sel[gi] != '0);
    assign w_iss_hit  = !reset && bus.iss_valid_i && (bus.iss_dst_reg_i == w_sel[gi]);
    assign w_rdata[gi] = w_bypass ? w_commit_data : r_regs[w_sel[gi]];
    assign w_rbusy[gi] = r_busy[w_sel[gi]] &
                         !(w_commit && (w_commit_reg == w_sel[gi]) && !w_iss_hit);
  end

  assign bus.alu_ready_o = w_alu_ready;
  assign bus.rs1_data_o  = w_rdata[0];
  assign bus.rs2_data_o  = w_rdata[1];
  assign bus.rs1_busy_o  = w_rbusy[0];
  assign bus.rs2_busy_o  = w_rbusy[1];
  assign bus.instret_o   = r_instret;
endmodule

// File: tb/tb_mr_wb.sv
// Directed bench for mr_wb: a per-cycle vector table followed by a
// hand-written reset-while-holding sequence.
module tb_mr_wb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mr_wb_if #(.XLEN(32), .REGSEL_BITS(5)) bus ();

  mr_wb #(.XLEN(32), .REGSEL_BITS(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic        lw;
    logic [31:0] ld;
    logic [4:0]  lr;
    logic        av;
    logic [31:0] ad;
    logic [4:0]  ar;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_rdy;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic [63:0] e_ins;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.ldst_write_i   = v.lw;
    bus.ldst_payload_i = v.ld;
    bus.ldst_dst_reg_i = v.lr;
    bus.alu_valid_i    = v.av;
    bus.alu_payload_i  = v.ad;
    bus.alu_dst_reg_i  = v.ar;
    bus.iss_valid_i    = v.iv;
    bus.iss_dst_reg_i  = v.ir;
    bus.rs1_sel_i      = v.s1;
    bus.rs2_sel_i      = v.s2;
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    vec_t v;
    v = '{1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 5'd0, s1, s2,
          1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 64'd0};
    drive(v);
  endtask

  task automatic check_row(input int idx, input vec_t v);
    chk($sformatf("row%0d alu_ready", idx), 64'(bus.alu_ready_o), 64'(v.e_rdy));
    chk($sformatf("row%0d rs1_data", idx), 64'(bus.rs1_data_o), 64'(v.e_d1));
    chk($sformatf("row%0d rs2_data", idx), 64'(bus.rs2_data_o), 64'(v.e_d2));
    chk($sformatf("row%0d rs1_busy", idx), 64'(bus.rs1_busy_o), 64'(v.e_b1));
    chk($sformatf("row%0d rs2_busy", idx), 64'(bus.rs2_busy_o), 64'(v.e_b2));
    chk($sformatf("row%0d instret", idx), bus.instret_o, v.e_ins);
    $display("row %0d: rdy=%0b rs1=0x%0h rs2=0x%0h busy=%0b%0b instret=%0d", idx,
             bus.alu_ready_o, bus.rs1_data_o, bus.rs2_data_o,
             bus.rs1_busy_o, bus.rs2_busy_o, bus.instret_o);
  endtask

  initial begin
    //           lw   ld            lr     av   ad            ar     iv   ir     s1     s2     rdy  d1            d2            b1   b2   ins
    vecs[0]  = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 64'd0};
    vecs[1]  = '{1'b0, 32'h0,        5'd0, 1'b1, 32'h1234,     5'd5, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 32'h1234,     32'h0,        1'b0, 1'b0, 64'd0};
    vecs[2]  = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd5, 5'd3, 1'b1, 32'h1234,     32'h0,        1'b0, 1'b0, 64'd1};
    vecs[3]  = '{1'b1, 32'hAAAA0000, 5'd3, 1'b1, 32'h55,       5'd4, 1'b0, 5'd0, 5'd3, 5'd4, 1'b1, 32'hAAAA0000, 32'h0,        1'b0, 1'b0, 64'd1};
    vecs[4]  = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd4, 5'd3, 1'b0, 32'h55,       32'hAAAA0000, 1'b0, 1'b0, 64'd2};
    vecs[5]  = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd4, 5'd0, 1'b1, 32'h55,       32'h0,        1'b0, 1'b0, 64'd3};
    vecs[6]  = '{1'b1, 32'h11,       5'd1, 1'b1, 32'h44,       5'd4, 1'b0, 5'd0, 5'd4, 5'd1, 1'b1, 32'h55,       32'h11,       1'b0, 1'b0, 64'd3};
    vecs[7]  = '{1'b1, 32'h22,       5'd2, 1'b1, 32'h66,       5'd6, 1'b0, 5'd0, 5'd4, 5'd2, 1'b0, 32'h55,       32'h22,       1'b0, 1'b0, 64'd4};
    vecs[8]  = '{1'b1, 32'h111,      5'd1, 1'b1, 32'h66,       5'd6, 1'b0, 5'd0, 5'd4, 5'd1, 1'b0, 32'h55,       32'h111,      1'b0, 1'b0, 64'd5};
    vecs[9]  = '{1'b1, 32'h222,      5'd2, 1'b1, 32'h66,       5'd6, 1'b0, 5'd0, 5'd4, 5'd2, 1'b0, 32'h55,       32'h222,      1'b0, 1'b0, 64'd6};
    vecs[10] = '{1'b0, 32'h0,        5'd0, 1'b1, 32'h66,       5'd6, 1'b0, 5'd0, 5'd4, 5'd6, 1'b0, 32'h44,       32'h0,        1'b0, 1'b0, 64'd7};
    vecs[11] = '{1'b0, 32'h0,        5'd0, 1'b1, 32'h66,       5'd6, 1'b0, 5'd0, 5'd6, 5'd4, 1'b1, 32'h66,       32'h44,       1'b0, 1'b0, 64'd8};
    vecs[12] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd6, 5'd1, 1'b1, 32'h66,       32'h111,      1'b0, 1'b0, 64'd9};
    vecs[13] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 64'd9};
    vecs[14] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 64'd9};
    vecs[15] = '{1'b0, 32'h0,        5'd0, 1'b1, 32'h9,        5'd7, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 32'h9,        32'h0,        1'b1, 1'b0, 64'd9};
    vecs[16] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 32'h9,        32'h0,        1'b1, 1'b0, 64'd10};
    vecs[17] = '{1'b0, 32'h0,        5'd0, 1'b1, 32'h10,       5'd7, 1'b0, 5'd0, 5'd7, 5'd7, 1'b1, 32'h10,       32'h10,       1'b0, 1'b0, 64'd10};
    vecs[18] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 32'h10,       32'h0,        1'b0, 1'b0, 64'd11};
    vecs[19] = '{1'b0, 32'h0,        5'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 64'd11};
    vecs[20] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 32'h0,        32'h1234,     1'b0, 1'b0, 64'd12};

    // Reset with LDST and issue asserted: both must be ignored.
    idle(5'd5, 5'd0);
    bus.ldst_write_i   = 1'b1;
    bus.ldst_payload_i = 32'hDEAD;
    bus.ldst_dst_reg_i = 5'd5;
    bus.iss_valid_i    = 1'b1;
    bus.iss_dst_reg_i  = 5'd5;
    reset = 1'b1;
    @(negedge clk);
    chk("reset alu_ready", 64'(bus.alu_ready_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_row(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Fill the holding buffer (LDST x8 commits, ALU x9 held), mark x10 busy.
    idle(5'd8, 5'd9);
    bus.ldst_write_i   = 1'b1;
    bus.ldst_payload_i = 32'h88;
    bus.ldst_dst_reg_i = 5'd8;
    bus.alu_valid_i    = 1'b1;
    bus.alu_payload_i  = 32'h99;
    bus.alu_dst_reg_i  = 5'd9;
    bus.iss_valid_i    = 1'b1;
    bus.iss_dst_reg_i  = 5'd10;
    @(negedge clk);
    chk("fill alu_ready", 64'(bus.alu_ready_o), 64'd1);
    chk("fill rs1 bypass x8", 64'(bus.rs1_data_o), 64'h88);
    $display("fill: rdy=%0b rs1=0x%0h instret=%0d", bus.alu_ready_o, bus.rs1_data_o, bus.instret_o);
    @(posedge clk);
    #1;

    // One reset cycle while the buffer is full, with more traffic offered.
    idle(5'd9, 5'd10);
    reset = 1'b1;
    bus.ldst_write_i   = 1'b1;
    bus.ldst_payload_i = 32'hBB;
    bus.ldst_dst_reg_i = 5'd11;
    bus.iss_valid_i    = 1'b1;
    bus.iss_dst_reg_i  = 5'd12;
    @(negedge clk);
    chk("hold reset alu_ready", 64'(bus.alu_ready_o), 64'd0);
    chk("hold reset instret before edge", bus.instret_o, 64'd13);
    $display("reset: rdy=%0b instret=%0d", bus.alu_ready_o, bus.instret_o);
    @(posedge clk);
    #1;
    reset = 1'b0;

    idle(5'd9, 5'd8);
    @(negedge clk);
    chk("post reset alu_ready", 64'(bus.alu_ready_o), 64'd1);
    chk("post reset x9", 64'(bus.rs1_data_o), 64'd0);
    chk("post reset x8", 64'(bus.rs2_data_o), 64'd0);
    chk("post reset busy1", 64'(bus.rs1_busy_o), 64'd0);
    chk("post reset instret", bus.instret_o, 64'd0);
    $display("post1: rdy=%0b x9=0x%0h x8=0x%0h instret=%0d", bus.alu_ready_o,
             bus.rs1_data_o, bus.rs2_data_o, bus.instret_o);
    @(posedge clk);
    #1;

    idle(5'd10, 5'd5);
    @(negedge clk);
    chk("post reset busy x10", 64'(bus.rs1_busy_o), 64'd0);
    chk("post reset x5", 64'(bus.rs2_data_o), 64'd0);
    chk("post reset held not committed", bus.instret_o, 64'd0);
    $display("post2: busy10=%0b x5=0x%0h instret=%0d", bus.rs1_busy_o,
             bus.rs2_data_o, bus.instret_o);
    @(posedge clk);
    #1;

    idle(5'd11, 5'd12);
    @(negedge clk);
    chk("post reset x11", 64'(bus.rs1_data_o), 64'd0);
    chk("post reset busy x12", 64'(bus.rs2_busy_o), 64'd0);
    $display("post3: x11=0x%0h busy12=%0b", bus.rs1_data_o, bus.rs2_busy_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
